div_scheduler: RTL and testbench
================================

Name: div_scheduler

Overview:
- Round-robin sequencer that shares one `processor` divider instance between NUM_CH gain-control channels.
- Accepts per-channel reference/error division requests and issues one operand pair at a time on the processor's `i_valid`.
- Waits the processor's fixed latency, captures `o_quotient`/`o_fractional`, and returns the result tagged with the channel index.
- Sits between the per-channel amplitude estimators and the shared `processor`.

Parameters:
- AMPLITUDE_DATA_SIZE, 13, width of reference/error operands
- QUOTIENT_SIZE, 8, integer part of gain result
- FRACTIONAL_SIZE, 8, fractional part of gain result
- NUM_CH, 4, number of requesting channels (2..16)
- CH_W, 2, channel index width, must equal clog2(NUM_CH)
- DIV_LATENCY, 2, cycles from processor `i_valid` to stable processor outputs (div_gen 1 + output register 1)

Ports:
- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_req  in  NUM_CH  per-channel request, level; operands must be stable while high
- i_reference  in  NUM_CH*AMPLITUDE_DATA_SIZE  packed divisors, channel k at bits [k*AMP +: AMP]
- i_error  in  NUM_CH*AMPLITUDE_DATA_SIZE  packed dividends, same packing
- o_grant  out  NUM_CH  one-hot, one-cycle pulse; operands captured; requester may drop req
- o_proc_reference  out  AMPLITUDE_DATA_SIZE  to processor `i_reference`
- o_proc_error  out  AMPLITUDE_DATA_SIZE  to processor `i_error`
- o_proc_valid  out  1  to processor `i_valid`, one-cycle pulse per operation
- i_proc_quotient  in  QUOTIENT_SIZE  from processor `o_quotient`
- i_proc_fractional  in  FRACTIONAL_SIZE  from processor `o_fractional`
- o_result_valid  out  1  one-cycle pulse, result fields valid
- o_result_channel  out  CH_W  channel owning the result
- o_quotient  out  QUOTIENT_SIZE  held result integer part
- o_fractional  out  FRACTIONAL_SIZE  held result fractional part
- o_div_by_zero  out  1  held flag, result produced by zero guard
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (`i_reset`=0 at a clock edge):
  - All outputs go to 0 and the state goes to IDLE.
  - The round-robin pointer goes to 0.
  - The latched channel and operands are cleared.
  - Reset mid-operation abandons the operation with no result pulse. The processor's late output is ignored.
- FSM states are IDLE, ISSUE, WAIT and DONE. All outputs are registered.
- IDLE:
  - If any i_req is high, select the first requesting channel at or after the pointer, wrapping modulo NUM_CH.
  - Latch its operands and channel index.
  - Pulse o_grant for that channel on the next cycle.
  - Go to ISSUE, or to DONE if the zero guard applies (see Optional Feature).
  - If no request is high, remain in IDLE.
- ISSUE (1 cycle):
  - o_proc_valid=1; o_proc_reference/o_proc_error carry the latched operands.
  - Load the wait counter with DIV_LATENCY-1.
  - Go to WAIT.
- WAIT:
  - Decrement the counter each cycle. o_proc_* operands stay held and o_proc_valid=0.
  - When the counter reaches 0, capture i_proc_quotient/i_proc_fractional into the result registers. This happens exactly DIV_LATENCY cycles after the ISSUE cycle.
  - Go to DONE.
- DONE (1 cycle):
  - o_result_valid=1.
  - o_result_channel = latched index; o_quotient/o_fractional/o_div_by_zero are updated.
  - Pointer = (granted channel + 1) mod NUM_CH.
  - Return to IDLE.
- Timing:
  - Request seen in IDLE at cycle T → grant pulse and o_proc_valid at T+1 → result sample at T+1+DIV_LATENCY → o_result_valid at T+2+DIV_LATENCY.
  - Throughput is one operation per DIV_LATENCY+3 cycles.
- Result fields hold their value until the next DONE.
- New requests are not sampled outside IDLE. i_req held high across an operation is serviced again only when its turn comes.
- A channel dropping i_req before grant is not serviced. No partial state is kept.
- If all channels request continuously, each channel is served once per NUM_CH operations. No starvation.
- Fairness: the pointer advances only on a completed operation (DONE), never on reset-abandoned ones.

Optional Feature:
- Macro: DIV_SCHEDULER_ZERO_GUARD_EN
- Defined:
  - In IDLE, a selected request with reference == 0 still gets its grant pulse, then skips ISSUE/WAIT.
  - It enters DONE the next cycle with o_quotient/o_fractional all ones (saturated max gain) and o_div_by_zero=1.
  - o_proc_valid is not pulsed.
  - Normal results set o_div_by_zero=0.
- Undefined:
  - Zero references are issued to the processor like any other operand pair; its output is returned unchanged.
  - o_div_by_zero is tied to 0.

Test Plan:
- Single request: ch0 ref=100, err=50, DIV_LATENCY=2, processor model returns 0x00/0x80 → o_grant=0001 at T+1, o_proc_valid at T+1, o_result_valid at T+4 with channel=0, quotient=0x00, fractional=0x80.
- Round robin: all four i_req held high for 20 cycles → result channels in order 0,1,2,3,0; o_proc_valid exactly once per 5 cycles.
- Pointer wrap: ch3 served, then only ch1 and ch0 requesting → ch0 granted first, then ch1.
- Reset mid-WAIT: assert i_reset=0 one cycle after o_proc_valid → all outputs 0 next cycle, no o_result_valid. After release, a ch2 request is granted with pointer starting from 0.
- Zero guard with macro defined: ch1 ref=0, err=7 → grant pulse, no o_proc_valid, o_result_valid two cycles after request with quotient=0xFF, fractional=0xFF, o_div_by_zero=1.
- Zero guard with macro undefined: same stimulus → o_proc_valid pulsed, processor output returned as-is, o_div_by_zero=0.

Source files
------------

// File: rtl/div_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : div_scheduler_if
// Brief     : Request, processor and result signals of div_scheduler.
// Revision  : 1.0
// ============================================================================
interface div_scheduler_if #(
    parameter int AMPLITUDE_DATA_SIZE = 13,
    parameter int QUOTIENT_SIZE       = 8,
    parameter int FRACTIONAL_SIZE     = 8,
    parameter int NUM_CH              = 4,
    parameter int CH_W                = 2
);
    logic [NUM_CH-1:0]                     i_req;
    logic [NUM_CH*AMPLITUDE_DATA_SIZE-1:0] i_reference;
    logic [NUM_CH*AMPLITUDE_DATA_SIZE-1:0] i_error;
    logic [NUM_CH-1:0]                     o_grant;
    logic [AMPLITUDE_DATA_SIZE-1:0]        o_proc_reference;
    logic [AMPLITUDE_DATA_SIZE-1:0]        o_proc_error;
    logic                                  o_proc_valid;
    logic [QUOTIENT_SIZE-1:0]              i_proc_quotient;
    logic [FRACTIONAL_SIZE-1:0]            i_proc_fractional;
    logic                                  o_result_valid;
    logic [CH_W-1:0]                       o_result_channel;
    logic [QUOTIENT_SIZE-1:0]              o_quotient;
    logic [FRACTIONAL_SIZE-1:0]            o_fractional;
    logic                                  o_div_by_zero;
    logic                                  o_busy;

    modport master (
        output i_req, i_reference, i_error, i_proc_quotient, i_proc_fractional,
        input  o_grant, o_proc_reference, o_proc_error, o_proc_valid,
               o_result_valid, o_result_channel, o_quotient, o_fractional,
               o_div_by_zero, o_busy
    );

    modport slave (
        input  i_req, i_reference, i_error, i_proc_quotient, i_proc_fractional,
        output o_grant, o_proc_reference, o_proc_error, o_proc_valid,
               o_result_valid, o_result_channel, o_quotient, o_fractional,
               o_div_by_zero, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/div_scheduler.sv
`default_nettype none
// ============================================================================
// Module    : div_scheduler
// Brief     : Round-robin sequencer sharing one divider among NUM_CH channels.
//             Optional zero-reference guard: DIV_SCHEDULER_ZERO_GUARD_EN
// Revision  : 1.0
// ============================================================================
module div_scheduler #(
    parameter int AMPLITUDE_DATA_SIZE = 13,
    parameter int QUOTIENT_SIZE       = 8,
    parameter int FRACTIONAL_SIZE     = 8,
    parameter int NUM_CH              = 4,
    parameter int CH_W                = 2,
    parameter int DIV_LATENCY         = 2
) (
    input wire              i_clock,
    input wire              i_reset,
    div_scheduler_if.slave  bus
);
    localparam int                  c_cnt_w    = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_load = c_cnt_w'(DIV_LATENCY - 1);
    localparam logic [NUM_CH-1:0]   c_one      = NUM_CH'(1);
    localparam logic [CH_W:0]       c_num_ch   = (CH_W+1)'(NUM_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                         r_state;
    logic [CH_W-1:0]                r_ptr;
    logic [CH_W-1:0]                r_ch;
    logic [AMPLITUDE_DATA_SIZE-1:0] r_ref;
    logic [AMPLITUDE_DATA_SIZE-1:0] r_err;
    logic [c_cnt_w-1:0]             r_cnt;
    logic [NUM_CH-1:0]              r_grant;
    logic                           r_proc_valid;
    logic                           r_result_valid;
    logic [CH_W-1:0]                r_result_channel;
    logic [QUOTIENT_SIZE-1:0]       r_quotient;
    logic [FRACTIONAL_SIZE-1:0]     r_fractional;
    logic                           r_busy;

    logic [AMPLITUDE_DATA_SIZE-1:0] w_ref_arr [NUM_CH];
    logic [AMPLITUDE_DATA_SIZE-1:0] w_err_arr [NUM_CH];
    logic                           w_sel_found;
    logic [CH_W-1:0]                w_sel_idx;
    logic [CH_W:0]                  w_ch_sum;
    logic [AMPLITUDE_DATA_SIZE-1:0] w_sel_ref;
    logic [AMPLITUDE_DATA_SIZE-1:0] w_sel_err;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign w_ref_arr[k] = bus.i_reference[k*AMPLITUDE_DATA_SIZE +: AMPLITUDE_DATA_SIZE];
        assign w_err_arr[k] = bus.i_error[k*AMPLITUDE_DATA_SIZE +: AMPLITUDE_DATA_SIZE];
    end

    // Scan offsets from far to near so the requester closest to the pointer wins.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_ch_sum    = '0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            w_ch_sum = {1'b0, r_ptr} + (CH_W+1)'(off);
            if (w_ch_sum >= c_num_ch) begin
                w_ch_sum = w_ch_sum - c_num_ch;
            end
            if (bus.i_req[w_ch_sum[CH_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_ch_sum[CH_W-1:0];
            end
        end
    end

    assign w_sel_ref = w_ref_arr[w_sel_idx];
    assign w_sel_err = w_err_arr[w_sel_idx];

`ifdef DIV_SCHEDULER_ZERO_GUARD_EN
    logic r_div_by_zero;
    logic r_guard_pend;
    logic w_sel_zero;

    assign w_sel_zero        = (w_sel_ref == '0);
    assign bus.o_div_by_zero = r_div_by_zero;
`else
    assign bus.o_div_by_zero = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state          <= IDLE;
            r_ptr            <= '0;
            r_ch             <= '0;
            r_ref            <= '0;
            r_err            <= '0;
            r_cnt            <= '0;
            r_grant          <= '0;
            r_proc_valid     <= 1'b0;
            r_result_valid   <= 1'b0;
            r_result_channel <= '0;
            r_quotient       <= '0;
            r_fractional     <= '0;
            r_busy           <= 1'b0;
`ifdef DIV_SCHEDULER_ZERO_GUARD_EN
            r_div_by_zero    <= 1'b0;
            r_guard_pend     <= 1'b0;
`endif
        end else begin
            r_grant        <= '0;
            r_proc_valid   <= 1'b0;
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sel_found) begin
                        r_ch    <= w_sel_idx;
                        r_ref   <= w_sel_ref;
                        r_err   <= w_sel_err;
                        r_grant <= c_one << w_sel_idx;
                        r_busy  <= 1'b1;
`ifdef DIV_SCHEDULER_ZERO_GUARD_EN
                        if (w_sel_zero) begin
                            r_guard_pend <= 1'b1;
                            r_state      <= DONE;
                        end else
`endif
                        begin
                            r_proc_valid <= 1'b1;
                            r_state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt   <= c_cnt_load;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_quotient       <= bus.i_proc_quotient;
                        r_fractional     <= bus.i_proc_fractional;
                        r_result_valid   <= 1'b1;
                        r_result_channel <= r_ch;
`ifdef DIV_SCHEDULER_ZERO_GUARD_EN
                        r_div_by_zero    <= 1'b0;
`endif
                        r_state          <= DONE;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                DONE: begin
`ifdef DIV_SCHEDULER_ZERO_GUARD_EN
                    // Guarded requests spend their grant cycle here, then publish.
                    if (r_guard_pend) begin
                        r_guard_pend     <= 1'b0;
                        r_quotient       <= '1;
                        r_fractional     <= '1;
                        r_div_by_zero    <= 1'b1;
                        r_result_valid   <= 1'b1;
                        r_result_channel <= r_ch;
                    end else
`endif
                    begin
                        r_ptr   <= (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_grant          = r_grant;
    assign bus.o_proc_reference = r_ref;
    assign bus.o_proc_error     = r_err;
    assign bus.o_proc_valid     = r_proc_valid;
    assign bus.o_result_valid   = r_result_valid;
    assign bus.o_result_channel = r_result_channel;
    assign bus.o_quotient       = r_quotient;
    assign bus.o_fractional     = r_fractional;
    assign bus.o_busy           = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_div_scheduler.sv
`default_nettype none
// ============================================================================
// Module    : tb_div_scheduler
// Brief     : Self-checking bench for div_scheduler with a latency-accurate divider stub.
// Revision  : 1.0
// ============================================================================
module tb_div_scheduler;
    localparam int AMP = 13;
    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int LAT = 2;

    typedef struct {
        int              t_g;
        logic [NCH-1:0]  g;
        int              n_pv;
        int              t_pv;
        logic [AMP-1:0]  pr;
        logic [AMP-1:0]  pe;
        int              t_rv;
        logic [CHW-1:0]  ch;
        logic [15:0]     res;
        logic            dz;
        logic            busy1;
    } op_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_ptr   = 0;
    logic [AMP-1:0] m_ref [NCH];
    logic [AMP-1:0] m_err [NCH];

    always #5 clk = ~clk;

    div_scheduler_if #(.AMPLITUDE_DATA_SIZE(AMP), .QUOTIENT_SIZE(8), .FRACTIONAL_SIZE(8),
                       .NUM_CH(NCH), .CH_W(CHW)) bus ();

    div_scheduler #(.AMPLITUDE_DATA_SIZE(AMP), .QUOTIENT_SIZE(8), .FRACTIONAL_SIZE(8),
                    .NUM_CH(NCH), .CH_W(CHW), .DIV_LATENCY(LAT)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    // Divider stub: 8.8 fixed-point err/ref, valid exactly LAT cycles after i_valid, noise otherwise.
    function automatic logic [15:0] div_model(input logic [AMP-1:0] r, input logic [AMP-1:0] e);
        logic [31:0] t;
        if (r == '0) return 16'hA5C3;
        t = {19'd0, e} << 8;
        t = t / {19'd0, r};
        return t[15:0];
    endfunction

    logic [LAT-1:0] vp    = '0;
    logic [15:0]    dp [LAT];
    logic [15:0]    noise = 16'h0;

    always @(posedge clk) begin
        noise <= 16'($urandom);
        for (int i = LAT - 1; i > 0; i--) begin
            vp[i] <= vp[i-1];
            dp[i] <= dp[i-1];
        end
        vp[0] <= bus.o_proc_valid;
        dp[0] <= div_model(bus.o_proc_reference, bus.o_proc_error);
    end

    assign bus.i_proc_quotient   = vp[LAT-1] ? dp[LAT-1][15:8] : noise[15:8];
    assign bus.i_proc_fractional = vp[LAT-1] ? dp[LAT-1][7:0]  : noise[7:0];

    function automatic int first_req(input logic [NCH-1:0] mask, input int ptr);
        int c;
        for (int off = 0; off < NCH; off++) begin
            c = (ptr + off) % NCH;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops();
        for (int k = 0; k < NCH; k++) begin
            bus.i_reference[k*AMP +: AMP] = m_ref[k];
            bus.i_error[k*AMP +: AMP]     = m_err[k];
        end
    endtask

    task automatic rand_ops();
        for (int k = 0; k < NCH; k++) begin
            m_ref[k] = AMP'($urandom_range(1, 8191));
            m_err[k] = AMP'($urandom);
        end
        load_ops();
    endtask

    task automatic watch(input int max_cyc, input bit drop, output op_t o);
        o.t_g = -1; o.g = '0; o.n_pv = 0; o.t_pv = -1; o.pr = '0; o.pe = '0;
        o.t_rv = -1; o.ch = '0; o.res = '0; o.dz = 1'b0; o.busy1 = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            if (c == 1) o.busy1 = bus.o_busy;
            if (bus.o_grant != '0 && o.t_g < 0) begin
                o.t_g = c;
                o.g   = bus.o_grant;
                if (drop) bus.i_req = bus.i_req & ~bus.o_grant;
            end
            if (bus.o_proc_valid) begin
                o.n_pv++;
                o.t_pv = c;
                o.pr   = bus.o_proc_reference;
                o.pe   = bus.o_proc_error;
            end
            if (bus.o_result_valid) begin
                o.t_rv = c;
                o.ch   = bus.o_result_channel;
                o.res  = {bus.o_quotient, bus.o_fractional};
                o.dz   = bus.o_div_by_zero;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_req = '0;
        rand_ops();
        repeat (3) tick();
        n_tests++;
        if ({bus.o_grant, bus.o_proc_valid, bus.o_result_valid, bus.o_busy, bus.o_div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: grant=%b pv=%b rv=%b busy=%b dz=%b, all required 0",
                     bus.o_grant, bus.o_proc_valid, bus.o_result_valid, bus.o_busy, bus.o_div_by_zero);
        end
        n_tests++;
        if ({bus.o_quotient, bus.o_fractional, bus.o_result_channel, bus.o_proc_reference, bus.o_proc_error} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: q=%h f=%h ch=%0d pref=%h perr=%h, all required 0",
                     bus.o_quotient, bus.o_fractional, bus.o_result_channel, bus.o_proc_reference, bus.o_proc_error);
        end
        rst_n = 1'b1;
        tick();
        m_ptr = 0;
    endtask

    task automatic test_single();
        op_t o;
        m_ref[0] = 13'd100;
        m_err[0] = 13'd50;
        load_ops();
        bus.i_req = 4'b0001;
        watch(12, 1'b1, o);
        bus.i_req = '0;
        n_tests++;
        if ({o.t_g, o.t_pv, o.t_rv} !== {32'd1, 32'd1, 32'(LAT + 2)}) begin
            n_fail++;
            $display("FAIL single_timing: grant/pv/result cycles %0d/%0d/%0d, required 1/1/%0d",
                     o.t_g, o.t_pv, o.t_rv, LAT + 2);
        end
        n_tests++;
        if ({o.g, o.n_pv, o.busy1} !== {4'b0001, 32'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b pv_count=%0d busy=%b, required 0001/1/1", o.g, o.n_pv, o.busy1);
        end
        n_tests++;
        if ({o.pr, o.pe, o.ch, o.res, o.dz} !== {13'd100, 13'd50, 2'd0, 16'h0080, 1'b0}) begin
            n_fail++;
            $display("FAIL single_result: pref=%0d perr=%0d ch=%0d q.f=%h dz=%b, required 100/50/0/0080/0",
                     o.pr, o.pe, o.ch, o.res, o.dz);
        end
        repeat (3) tick();
        n_tests++;
        if ({bus.o_quotient, bus.o_fractional, bus.o_result_valid, bus.o_busy} !== {16'h0080, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_hold: q.f=%h rv=%b busy=%b, required 0080/0/0",
                     {bus.o_quotient, bus.o_fractional}, bus.o_result_valid, bus.o_busy);
        end
        m_ptr = 1;
    endtask

    task automatic test_random_ops();
        op_t            o;
        logic [NCH-1:0] mask;
        logic [NCH-1:0] eg;
        int             exp;
        for (int it = 0; it < 10; it++) begin
            rand_ops();
            mask = NCH'($urandom_range(1, (1 << NCH) - 1));
            exp  = first_req(mask, m_ptr);
            eg   = '0;
            eg[exp] = 1'b1;
            bus.i_req = mask;
            watch(12, 1'b0, o);
            bus.i_req = '0;
            tick();
            n_tests++;
            if ({o.g, o.ch, o.t_g, o.t_pv, o.t_rv, o.n_pv} !== {eg, CHW'(exp), 32'd1, 32'd1, 32'(LAT + 2), 32'd1}) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: mask=%b grant=%b ch=%0d cycles %0d/%0d/%0d pvs=%0d, required grant=%b ch=%0d cycles 1/1/%0d pvs=1",
                         it, mask, o.g, o.ch, o.t_g, o.t_pv, o.t_rv, o.n_pv, eg, exp, LAT + 2);
            end
            n_tests++;
            if ({o.res, o.dz, o.pr, o.pe} !== {div_model(m_ref[exp], m_err[exp]), 1'b0, m_ref[exp], m_err[exp]}) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: q.f=%h dz=%b pref=%h perr=%h, required %h/0/%h/%h",
                         it, o.res, o.dz, o.pr, o.pe, div_model(m_ref[exp], m_err[exp]), m_ref[exp], m_err[exp]);
            end
            m_ptr = (exp + 1) % NCH;
        end
    endtask

    task automatic test_round_robin();
        int exp;
        int last_pv;
        int nres;
        int npv;
        rand_ops();
        exp     = m_ptr;
        last_pv = -1;
        nres    = 0;
        npv     = 0;
        bus.i_req = '1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.o_proc_valid) begin
                npv++;
                if (last_pv >= 0) begin
                    n_tests++;
                    if (c - last_pv !== LAT + 3) begin
                        n_fail++;
                        $display("FAIL rr_spacing: pv gap %0d cycles, required %0d", c - last_pv, LAT + 3);
                    end
                end
                last_pv = c;
            end
            if (bus.o_result_valid) begin
                n_tests++;
                if ({bus.o_result_channel, bus.o_quotient, bus.o_fractional} !== {CHW'(exp), div_model(m_ref[exp], m_err[exp])}) begin
                    n_fail++;
                    $display("FAIL rr_result: ch=%0d q.f=%h, required ch=%0d q.f=%h", bus.o_result_channel,
                             {bus.o_quotient, bus.o_fractional}, exp, div_model(m_ref[exp], m_err[exp]));
                end
                exp = (exp + 1) % NCH;
                nres++;
            end
            if (c == 4 * (LAT + 3) + 1) bus.i_req = '0;
        end
        n_tests++;
        if (nres !== 5 || npv !== 5) begin
            n_fail++;
            $display("FAIL rr_count: results=%0d pvs=%0d, required 5/5", nres, npv);
        end
        m_ptr = exp;
    endtask

    task automatic test_wrap();
        op_t o;
        rand_ops();
        bus.i_req = 4'b1000;
        watch(12, 1'b1, o);
        bus.i_req = '0;
        tick();
        n_tests++;
        if (o.ch !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_ch3: ch=%0d, required 3", o.ch);
        end
        bus.i_req = 4'b0011;
        watch(12, 1'b1, o);
        n_tests++;
        if ({o.g, o.ch} !== {4'b0001, 2'd0}) begin
            n_fail++;
            $display("FAIL wrap_first: grant=%b ch=%0d, required 0001/0", o.g, o.ch);
        end
        watch(14, 1'b1, o);
        n_tests++;
        if ({o.g, o.ch, o.res} !== {4'b0010, 2'd1, div_model(m_ref[1], m_err[1])}) begin
            n_fail++;
            $display("FAIL wrap_second: grant=%b ch=%0d q.f=%h, required 0010/1/%h", o.g, o.ch, o.res,
                     div_model(m_ref[1], m_err[1]));
        end
        bus.i_req = '0;
        tick();
        m_ptr = 2;
    endtask

    task automatic test_drop();
        int exp;
        int other;
        int grants;
        int nres;
        rand_ops();
        exp    = m_ptr;
        other  = (m_ptr + 2) % NCH;
        grants = 0;
        nres   = 0;
        bus.i_req = '0;
        bus.i_req[exp] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.o_grant != '0) grants++;
            if (bus.o_result_valid) nres++;
            if (c == 1) bus.i_req = '0;
            if (c == 2) bus.i_req[other] = 1'b1;
            if (c == 3) bus.i_req[other] = 1'b0;
        end
        n_tests++;
        if (grants !== 1 || nres !== 1 || bus.o_result_channel !== CHW'(exp)) begin
            n_fail++;
            $display("FAIL drop_before_grant: grants=%0d results=%0d ch=%0d, required 1/1/%0d",
                     grants, nres, bus.o_result_channel, exp);
        end
        m_ptr = (exp + 1) % NCH;
    endtask

    task automatic test_reset_mid();
        op_t o;
        int  stray;
        rand_ops();
        bus.i_req = 4'b0010;
        watch(12, 1'b1, o);
        bus.i_req = '0;
        tick();
        n_tests++;
        if (o.ch !== 2'd1) begin
            n_fail++;
            $display("FAIL rmid_pre: ch=%0d, required 1", o.ch);
        end
        bus.i_req = 4'b1000;
        tick();
        tick();
        rst_n = 1'b0;
        bus.i_req = '0;
        tick();
        n_tests++;
        if ({bus.o_grant, bus.o_proc_valid, bus.o_result_valid, bus.o_busy, bus.o_quotient, bus.o_fractional,
             bus.o_result_channel, bus.o_proc_reference, bus.o_proc_error} !== '0) begin
            n_fail++;
            $display("FAIL rmid_clear: grant=%b pv=%b rv=%b busy=%b q.f=%h ch=%0d pref=%h perr=%h, all required 0",
                     bus.o_grant, bus.o_proc_valid, bus.o_result_valid, bus.o_busy,
                     {bus.o_quotient, bus.o_fractional}, bus.o_result_channel, bus.o_proc_reference, bus.o_proc_error);
        end
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.o_result_valid || bus.o_grant != '0) stray++;
        end
        n_tests++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL rmid_no_result: stray grant/result cycles=%0d, required 0", stray);
        end
        m_ptr = 0;
        rand_ops();
        bus.i_req = 4'b0101;
        watch(12, 1'b1, o);
        n_tests++;
        if (o.ch !== 2'd0) begin
            n_fail++;
            $display("FAIL rmid_ptr_reset: ch=%0d, required 0", o.ch);
        end
        watch(14, 1'b1, o);
        n_tests++;
        if ({o.ch, o.res} !== {2'd2, div_model(m_ref[2], m_err[2])}) begin
            n_fail++;
            $display("FAIL rmid_ch2: ch=%0d q.f=%h, required 2/%h", o.ch, o.res, div_model(m_ref[2], m_err[2]));
        end
        bus.i_req = '0;
        tick();
        m_ptr = 3;
    endtask

    task automatic test_zero_ref();
        op_t o;
        rand_ops();
        m_ref[1] = '0;
        m_err[1] = 13'd7;
        load_ops();
        bus.i_req = 4'b0010;
        watch(12, 1'b1, o);
        bus.i_req = '0;
        tick();
`ifdef DIV_SCHEDULER_ZERO_GUARD_EN
        n_tests++;
        if ({o.g, o.t_g, o.n_pv, o.t_rv} !== {4'b0010, 32'd1, 32'd0, 32'd2}) begin
            n_fail++;
            $display("FAIL zero_timing: grant=%b cycles g=%0d rv=%0d pvs=%0d, required 0010 g=1 rv=2 pvs=0",
                     o.g, o.t_g, o.t_rv, o.n_pv);
        end
        n_tests++;
        if ({o.ch, o.res, o.dz} !== {2'd1, 16'hFFFF, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_result: ch=%0d q.f=%h dz=%b, required 1/FFFF/1", o.ch, o.res, o.dz);
        end
`else
        n_tests++;
        if ({o.g, o.t_g, o.n_pv, o.t_pv, o.t_rv} !== {4'b0010, 32'd1, 32'd1, 32'd1, 32'(LAT + 2)}) begin
            n_fail++;
            $display("FAIL zero_timing: grant=%b cycles g=%0d pv=%0d rv=%0d pvs=%0d, required 0010 1/1/%0d pvs=1",
                     o.g, o.t_g, o.t_pv, o.t_rv, o.n_pv, LAT + 2);
        end
        n_tests++;
        if ({o.ch, o.res, o.dz} !== {2'd1, div_model(13'd0, 13'd7), 1'b0}) begin
            n_fail++;
            $display("FAIL zero_result: ch=%0d q.f=%h dz=%b, required 1/%h/0", o.ch, o.res, o.dz,
                     div_model(13'd0, 13'd7));
        end
`endif
        bus.i_req = 4'b0100;
        watch(12, 1'b1, o);
        bus.i_req = '0;
        tick();
        n_tests++;
        if ({o.ch, o.res, o.dz} !== {2'd2, div_model(m_ref[2], m_err[2]), 1'b0}) begin
            n_fail++;
            $display("FAIL zero_then_normal: ch=%0d q.f=%h dz=%b, required 2/%h/0", o.ch, o.res, o.dz,
                     div_model(m_ref[2], m_err[2]));
        end
        m_ptr = 3;
    endtask

    initial begin
        bus.i_req       = '0;
        bus.i_reference = '0;
        bus.i_error     = '0;
        test_reset();
        test_single();
        test_random_ops();
        test_round_robin();
        test_wrap();
        test_drop();
        test_reset_mid();
        test_zero_ref();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion before 100000");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
